// File: rtl/piezo_seq.sv
// piezo_seq: melody sequencer for the piezo buzzer.
// Plays entries {op, half_period} from a loadable note RAM, advancing one
// entry per tempo tick derived from clk1mhz (no derived clocks), and drives
// a square wave plus LED beat/tone indication.
// Optional build macro PIEZO_SEQ_TEMPO_EN adds tempo_div[3:0]; the step
// period becomes DIV*(tempo_div+1), sampled when playback starts.
module piezo_seq #(
  parameter int CLK_HZ  = 1000000,
  parameter int STEP_HZ = 10,
  parameter int AW      = 10,
  parameter int HP_W    = 12
) (
  input  logic            clk1mhz,
  input  logic            reset,
  input  logic            play,
  input  logic            loop_en,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [HP_W+1:0] wr_data,
`ifdef PIEZO_SEQ_TEMPO_EN
  input  logic [3:0]      tempo_div,
`endif
  output logic            piezoout,
  output logic [15:0]     led,
  output logic            busy,
  output logic [AW-1:0]   step_addr,
  output logic            done,
  output logic            wr_err
);

  localparam int DIV   = CLK_HZ / STEP_HZ;
  localparam int DEPTH = 2 ** AW;
`ifdef PIEZO_SEQ_TEMPO_EN
  localparam int PMAX  = DIV * 16;
`else
  localparam int PMAX  = DIV;
`endif
  localparam int PW    = $clog2(PMAX + 1);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WAIT} state_t;
  typedef enum logic [1:0] {OP_HOLD = 2'b00, OP_NOTE = 2'b01,
                            OP_REST = 2'b10, OP_END  = 2'b11} op_t;

  state_t          state, state_d;
  logic [AW-1:0]   addr, addr_d;
  logic [PW-1:0]   presc, presc_d;
  logic [PW-1:0]   period, period_d;
  logic [HP_W-1:0] hp, hp_d;
  logic [HP_W-1:0] tcnt, tcnt_d;
  logic            tone_on, tone_on_d;
  logic            buff, buff_d;
  logic            done_d;
  logic [15:0]     led_d;
  logic [HP_W+1:0] rdata;
  logic [HP_W+1:0] mem [DEPTH];
  logic            step_tick;

  assign busy      = (state != IDLE);
  assign step_addr = addr;
  assign step_tick = busy && (presc == period - PW'(1));

`ifdef PIEZO_SEQ_TEMPO_EN
  // Step period is captured once on leaving IDLE so tempo changes mid-song are ignored.
  always_comb period_d = (state == IDLE && play) ? PW'(DIV * (int'(tempo_div) + 1)) : period;

  // Holds the captured step period.
  always_ff @(posedge clk1mhz or negedge reset)
    if (!reset) period <= PW'(DIV);
    else        period <= period_d;
`else
  assign period   = PW'(DIV);
  assign period_d = period;
`endif

  // Note RAM: writes only while idle, registered read of the current entry.
  // NOTE: the RAM array has no reset; its contents survive reset and only the control state is cleared.
  always_ff @(posedge clk1mhz) begin
    if (wr_en && !busy) mem[wr_addr] <= wr_data;
    if (state == READ)  rdata        <= mem[addr];
  end

  // Next-state, tone generator and output decode.
  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    state_d   = state;
    addr_d    = addr;
    hp_d      = hp;
    tcnt_d    = tcnt;
    tone_on_d = tone_on;
    buff_d    = buff;
    done_d    = 1'b0;

    // Tone counter runs 0..hp-1 and flips buff at the top; hp=0 is silence.
    if (tone_on && hp != '0) begin
      if (tcnt >= hp - HP_W'(1)) begin
        tcnt_d = '0;
        buff_d = ~buff;
      end else begin
        tcnt_d = tcnt + HP_W'(1);
      end
    end

    case (state)
      IDLE: if (play) begin
        addr_d  = '0;
        state_d = READ;
      end
      READ: state_d = EXEC;
      EXEC: begin
        state_d = WAIT;
        case (op_t'(rdata[HP_W+1:HP_W]))
          OP_NOTE: begin
            hp_d      = rdata[HP_W-1:0];
            tone_on_d = 1'b1;
            tcnt_d    = '0;
            buff_d    = 1'b0;
          end
          OP_REST: tone_on_d = 1'b0;
          OP_HOLD: ;
          OP_END: begin
            // Restart from entry 0 immediately; END at entry 0 would spin forever, so it finishes.
            if (loop_en && addr != '0) begin
              addr_d  = '0;
              state_d = READ;
            end else begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        endcase
      end
      WAIT: if (step_tick) begin
        if (addr == {AW{1'b1}}) begin
          if (loop_en) begin
            addr_d  = '0;
            state_d = READ;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          addr_d  = addr + AW'(1);
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase

    // Stopping overrides everything and rewinds silently.
    if (!play) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end
    if (state_d == IDLE) begin
      addr_d    = '0;
      tone_on_d = 1'b0;
      buff_d    = 1'b0;
    end

    // Prescaler is held at 0 in IDLE, so it starts from 0 on leaving IDLE.
    if (state == IDLE || state_d == IDLE) presc_d = '0;
    else if (step_tick)                   presc_d = '0;
    else                                  presc_d = presc + PW'(1);

    led_d = '0;
    if (state_d != IDLE && presc_d < (period_d >> 1))
      led_d = {8'hFF, tone_on_d ? 8'hFF : 8'h00};
  end

  // State and registered outputs; reset also silences the pin asynchronously.
  always_ff @(posedge clk1mhz or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      addr     <= '0;
      presc    <= '0;
      hp       <= '0;
      tcnt     <= '0;
      tone_on  <= 1'b0;
      buff     <= 1'b0;
      done     <= 1'b0;
      wr_err   <= 1'b0;
      led      <= '0;
      piezoout <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
      state    <= state_d;
      addr     <= addr_d;
      presc    <= presc_d;
      hp       <= hp_d;
      tcnt     <= tcnt_d;
      tone_on  <= tone_on_d;
      buff     <= buff_d;
      done     <= done_d;
      wr_err   <= wr_en && busy;
      led      <= led_d;
      piezoout <= buff_d & tone_on_d;
    end
  end

endmodule

// File: tb/tb_piezo_seq.sv
// Directed testbench for piezo_seq (DIV=10). Cycle c is sampled on the
// negedge after the c-th rising edge counted from the edge that first sees play=1.
module tb_piezo_seq;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_NOTE = 2'b01;
  localparam logic [1:0] OP_REST = 2'b10;
  localparam logic [1:0] OP_END  = 2'b11;

  logic        clk1mhz, reset;
  logic        play, loop_en, wr_en;
  logic [3:0]  wr_addr;
  logic [13:0] wr_data;
  logic        piezoout, busy, done, wr_err;
  logic [15:0] led;
  logic [3:0]  step_addr;

  logic        play2, loop_en2, wr_en2;
  logic [1:0]  wr_addr2;
  logic [13:0] wr_data2;
  logic        piezoout2, busy2, done2, wr_err2;
  logic [15:0] led2;
  logic [1:0]  step_addr2;

  int errors = 0;
  int checks = 0;

  piezo_seq #(.CLK_HZ(1000), .STEP_HZ(100), .AW(4), .HP_W(12)) dut (
`ifdef PIEZO_SEQ_TEMPO_EN
    .tempo_div(4'd0),
`endif
    .clk1mhz(clk1mhz), .reset(reset), .play(play), .loop_en(loop_en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .piezoout(piezoout), .led(led), .busy(busy), .step_addr(step_addr),
    .done(done), .wr_err(wr_err)
  );

  piezo_seq #(.CLK_HZ(1000), .STEP_HZ(100), .AW(2), .HP_W(12)) dut2 (
`ifdef PIEZO_SEQ_TEMPO_EN
    .tempo_div(4'd0),
`endif
    .clk1mhz(clk1mhz), .reset(reset), .play(play2), .loop_en(loop_en2),
    .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .piezoout(piezoout2), .led(led2), .busy(busy2), .step_addr(step_addr2),
    .done(done2), .wr_err(wr_err2)
  );

  initial begin
    clk1mhz = 1'b0;
    forever #5 clk1mhz = ~clk1mhz;
  end

  function automatic logic [13:0] ent(input logic [1:0] op, input int hp);
    return {op, 12'(hp)};
  endfunction

  task automatic wr(input logic [3:0] a, input logic [13:0] d);
    @(negedge clk1mhz);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk1mhz);
    wr_en = 1'b0;
  endtask

  task automatic wr2(input logic [1:0] a, input logic [13:0] d);
    @(negedge clk1mhz);
    wr_en2 = 1'b1; wr_addr2 = a; wr_data2 = d;
    @(negedge clk1mhz);
    wr_en2 = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    play = 0; loop_en = 0; wr_en = 0; wr_addr = '0; wr_data = '0;
    play2 = 0; loop_en2 = 0; wr_en2 = 0; wr_addr2 = '0; wr_data2 = '0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk1mhz);
    checks++;
    if ({piezoout, busy, done, wr_err} !== 4'b0000)
      begin errors++; $display("FAIL reset_bits: got %b expected 0000", {piezoout, busy, done, wr_err}); end
    checks++;
    if (led !== 16'h0 || step_addr !== 4'h0)
      begin errors++; $display("FAIL reset_led_addr: got led=%h addr=%0d expected 0/0", led, step_addr); end
    reset = 1'b1;
    @(negedge clk1mhz);
    checks++;
    if ({busy, busy2, piezoout, led} !== 19'h0)
      begin errors++; $display("FAIL reset_release: got busy=%b busy2=%b led=%h expected idle", busy, busy2, led); end
  endtask

  task automatic test_single_pass;
    int done_cnt, done_at;
    logic exp_p, exp_b;
    logic [15:0] exp_led;
    wr(0, ent(OP_NOTE, 3)); wr(1, ent(OP_HOLD, 0));
    wr(2, ent(OP_REST, 0)); wr(3, ent(OP_END, 0));
    loop_en = 0; done_cnt = 0; done_at = -1;
    @(negedge clk1mhz) play = 1'b1;
    for (int c = 0; c < 34; c++) begin
      @(negedge clk1mhz);
      exp_p = (c >= 2 && c < 22) ? (((c - 2) / 3) % 2 == 1) : 1'b0;
      exp_b = (c < 32);
      exp_led = (c < 32 && (c % 10) < 5) ? {8'hFF, (c >= 2 && c < 22) ? 8'hFF : 8'h00} : 16'h0;
      checks++;
      if (piezoout !== exp_p) begin errors++; $display("FAIL pass_tone c=%0d: got %b expected %b", c, piezoout, exp_p); end
      checks++;
      if (busy !== exp_b) begin errors++; $display("FAIL pass_busy c=%0d: got %b expected %b", c, busy, exp_b); end
      checks++;
      if (led !== exp_led) begin errors++; $display("FAIL pass_led c=%0d: got %h expected %h", c, led, exp_led); end
      if (c % 10 == 0 && c < 32) begin
        checks++;
        if (step_addr !== 4'(c / 10)) begin errors++; $display("FAIL pass_addr c=%0d: got %0d expected %0d", c, step_addr, c / 10); end
      end
      if (done === 1'b1) begin done_cnt++; done_at = c; end
      if (c == 32) play = 1'b0;
    end
    checks++;
    if (done_cnt != 1 || done_at != 32)
      begin errors++; $display("FAIL pass_done: got count=%0d at=%0d expected 1 at 32", done_cnt, done_at); end
  endtask

  task automatic test_loop;
    int exp_a;
    loop_en = 1;
    @(negedge clk1mhz) play = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk1mhz);
      exp_a = (c < 10) ? 0 : (c < 20) ? 1 : (c < 30) ? 2 : (c < 32) ? 3 : (c < 40) ? 0 : 1;
      checks++;
      if (step_addr !== 4'(exp_a)) begin errors++; $display("FAIL loop_addr c=%0d: got %0d expected %0d", c, step_addr, exp_a); end
      checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL loop_state c=%0d: got done=%b busy=%b expected 0/1", c, done, busy); end
    end
    play = 1'b0; loop_en = 0;
    @(negedge clk1mhz);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL loop_stop: got busy=%b expected 0", busy); end
  endtask

  task automatic test_stop;
    @(negedge clk1mhz) play = 1'b1;
    for (int c = 0; c <= 12; c++) @(negedge clk1mhz);
    checks++;
    if (piezoout !== 1'b1 || step_addr !== 4'd1)
      begin errors++; $display("FAIL stop_pre: got tone=%b addr=%0d expected 1/1", piezoout, step_addr); end
    play = 1'b0;
    @(negedge clk1mhz);
    checks++;
    if ({busy, piezoout, done} !== 3'b000 || step_addr !== 4'd0 || led !== 16'h0)
      begin errors++; $display("FAIL stop_post: got busy=%b tone=%b done=%b addr=%0d led=%h expected all 0", busy, piezoout, done, step_addr, led); end
    @(negedge clk1mhz);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL stop_nodone: got %b expected 0", done); end
    play = 1'b1;
    for (int c = 0; c <= 5; c++) @(negedge clk1mhz);
    checks++;
    if (piezoout !== 1'b1 || step_addr !== 4'd0 || busy !== 1'b1)
      begin errors++; $display("FAIL stop_restart: got tone=%b addr=%0d busy=%b expected 1/0/1", piezoout, step_addr, busy); end
    play = 1'b0;
    @(negedge clk1mhz);
  endtask

  task automatic test_wr_drop;
    for (int i = 0; i < 5; i++) wr(4'(i), ent(OP_HOLD, 0));
    wr(5, ent(OP_NOTE, 2)); wr(6, ent(OP_END, 0));
    checks++;
    if (wr_err !== 1'b0) begin errors++; $display("FAIL wr_idle: got wr_err=%b expected 0", wr_err); end
    @(negedge clk1mhz) play = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk1mhz);
      if (c == 3) begin wr_en = 1'b1; wr_addr = 4'd5; wr_data = ent(OP_NOTE, 1); end
      if (c == 4) begin
        wr_en = 1'b0;
        checks++;
        if (wr_err !== 1'b1) begin errors++; $display("FAIL wr_err_pulse: got %b expected 1", wr_err); end
      end
      if (c == 5) begin
        checks++;
        if (wr_err !== 1'b0) begin errors++; $display("FAIL wr_err_once: got %b expected 0", wr_err); end
      end
    end
    play = 1'b0;
    @(negedge clk1mhz) play = 1'b1;
    for (int c = 0; c <= 57; c++) begin
      @(negedge clk1mhz);
      if (c == 53 || c == 54 || c == 56) begin
        checks++;
        if (piezoout !== (c == 54)) begin errors++; $display("FAIL wr_old_data c=%0d: got %b expected %b", c, piezoout, c == 54); end
      end
    end
    play = 1'b0;
    @(negedge clk1mhz);
  endtask

  task automatic test_hp_edge;
    logic exp_p;
    wr(0, ent(OP_NOTE, 0)); wr(1, ent(OP_NOTE, 1)); wr(2, ent(OP_END, 0));
    @(negedge clk1mhz) play = 1'b1;
    for (int c = 0; c <= 22; c++) begin
      @(negedge clk1mhz);
      exp_p = (c >= 12 && c < 22) ? ((c - 12) % 2 == 1) : 1'b0;
      checks++;
      if (piezoout !== exp_p) begin errors++; $display("FAIL hp_tone c=%0d: got %b expected %b", c, piezoout, exp_p); end
      if (c == 3) begin
        checks++;
        if (led !== 16'hFFFF) begin errors++; $display("FAIL hp0_led: got %h expected ffff", led); end
      end
      if (c == 22) begin
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL hp_done: got done=%b busy=%b expected 1/0", done, busy); end
        play = 1'b0;
      end
    end
  endtask

  task automatic test_wrap;
    int dcnt;
    for (int i = 0; i < 4; i++) wr2(2'(i), ent(OP_HOLD, 0));
    loop_en2 = 0;
    @(negedge clk1mhz) play2 = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk1mhz);
      if (c == 35) begin
        checks++;
        if (step_addr2 !== 2'd3) begin errors++; $display("FAIL wrap_addr3: got %0d expected 3", step_addr2); end
      end
      if (c == 39) begin
        checks++;
        if (done2 !== 1'b0) begin errors++; $display("FAIL wrap_early_done: got %b expected 0", done2); end
      end
      if (c == 40) begin
        checks++;
        if (done2 !== 1'b1 || busy2 !== 1'b0) begin errors++; $display("FAIL wrap_done: got done=%b busy=%b expected 1/0", done2, busy2); end
        play2 = 1'b0;
      end
    end
    loop_en2 = 1; dcnt = 0;
    @(negedge clk1mhz) play2 = 1'b1;
    for (int c = 0; c <= 41; c++) begin
      @(negedge clk1mhz);
      if (done2 === 1'b1) dcnt++;
      if (c == 40) begin
        checks++;
        if (step_addr2 !== 2'd0 || busy2 !== 1'b1) begin errors++; $display("FAIL wrap_loop: got addr=%0d busy=%b expected 0/1", step_addr2, busy2); end
      end
    end
    checks++;
    if (dcnt != 0) begin errors++; $display("FAIL wrap_loop_done: got %0d pulses expected 0", dcnt); end
    play2 = 1'b0; loop_en2 = 0;
    @(negedge clk1mhz);
  endtask

  task automatic test_async_reset;
    wr(0, ent(OP_NOTE, 1));
    @(negedge clk1mhz) play = 1'b1;
    for (int c = 0; c <= 3; c++) @(negedge clk1mhz);
    checks++;
    if (piezoout !== 1'b1) begin errors++; $display("FAIL areset_pre: got %b expected 1", piezoout); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (piezoout !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL areset_async: got tone=%b busy=%b expected 0/0", piezoout, busy); end
    play = 1'b0;
    @(negedge clk1mhz) reset = 1'b1;
    @(negedge clk1mhz);
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_loop();
    test_stop();
    test_wr_drop();
    test_hp_edge();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
